// File: rtl/fifo_pkg.sv
// Shared constants for the FIFO read controller: output buffer depth and
// burst FSM state encoding.
package fifo_pkg;

    // Output buffer holds at most this many beats.
    localparam int BUF_DEPTH = 2;

    // Burst FSM state encoding.
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_BURST = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

endpackage

// File: rtl/fifo_rd_skid.sv
// Two-entry in-order output buffer. Entry 0 is always the head; a pop
// shifts entry 1 down. occ_o reports how many entries are valid.
module fifo_rd_skid
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push_i,
    input  logic [DATA_WIDTH-1:0] din_i,
    input  logic                  pop_i,
    output logic [1:0]            occ_o,
    output logic [DATA_WIDTH-1:0] dout_o
);

    logic [1:0]            occ_q, occ_d;
    logic [DATA_WIDTH-1:0] e0_q, e0_d;
    logic [DATA_WIDTH-1:0] e1_q, e1_d;
    logic                  full;
    logic                  do_pop;

    assign full   = (occ_q == 2'(BUF_DEPTH));
    assign do_pop = pop_i && (occ_q != 2'd0);

    // Next-state for occupancy and entries; push while full is dropped
    // unless a pop frees a slot in the same cycle.
    always_comb begin
        occ_d = occ_q;
        e0_d  = e0_q;
        e1_d  = e1_q;
        case ({push_i, do_pop})
            2'b10: begin
                if (!full) begin
                    if (occ_q == 2'd0) e0_d = din_i;
                    else               e1_d = din_i;
                    occ_d = occ_q + 2'd1;
                end
            end
            2'b01: begin
                e0_d  = e1_q;
                occ_d = occ_q - 2'd1;
            end
            2'b11: begin
                // Occupancy unchanged; new beat lands behind the survivor.
                if (occ_q == 2'd1) begin
                    e0_d = din_i;
                end else begin
                    e0_d = e1_q;
                    e1_d = din_i;
                end
            end
            default: ;
        endcase
    end

    // Buffer registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            occ_q <= 2'd0;
            e0_q  <= '0;
            e1_q  <= '0;
        end else begin
            occ_q <= occ_d;
            e0_q  <= e0_d;
            e1_q  <= e1_d;
        end
    end

    assign occ_o  = occ_q;
    assign dout_o = e0_q;

endmodule

// File: rtl/fifo_rd_ctrl.sv
// FIFO read controller: pulls words from a synchronous-read FIFO into a
// two-entry output buffer and presents them as a valid/ready stream.
// Reads are credit-limited so the buffer can never overflow, giving one
// beat per cycle when the sink is always ready.
// Build option: define FIFO_RD_CTRL_BURST_EN to gate reads through an
// IDLE/BURST/DRAIN FSM issuing BURST_LEN-beat bursts.
module fifo_rd_ctrl
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int BURST_LEN  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  fifo_empty,
    input  logic                  fifo_almost_empty,
    input  logic [DATA_WIDTH-1:0] fifo_dout,
    output logic                  fifo_rd_en,
    input  logic                  flush,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  busy
);

    localparam logic [4:0] BL = 5'(BURST_LEN);

    logic                  pending_q, pending_d;
    logic [1:0]            occ;
    logic                  pop;
    logic                  credit_ok;
    logic                  rd_gate;
    logic                  busy_int;
    logic [2:0]            fill_cnt;
    logic [2:0]            limit;

    // A read issued now lands in the buffer after the word returns, so
    // count it against the buffer as soon as it is in flight.
    assign fill_cnt  = {1'b0, occ} + {2'b00, pending_q};
    assign limit     = 3'(BUF_DEPTH) + {2'b00, pop};
    assign credit_ok = (fill_cnt < limit);

    assign pop        = out_valid && out_ready;
    assign busy_int   = pending_q || (occ != 2'd0);
    assign fifo_rd_en = !rst && !fifo_empty && credit_ok && rd_gate;
    assign out_valid  = !rst && (occ != 2'd0);
    assign busy       = !rst && busy_int;
    assign pending_d  = fifo_rd_en;

    // Tracks the read whose data appears on fifo_dout next cycle.
    always_ff @(posedge clk) begin
        if (rst) pending_q <= 1'b0;
        else     pending_q <= pending_d;
    end

`ifdef FIFO_RD_CTRL_BURST_EN
    logic [1:0] state_q, state_d;
    logic [4:0] cnt_q, cnt_d;

    assign rd_gate = (state_q == ST_BURST);

    // Burst sequencing: start on enough data or flush, stop after
    // BURST_LEN reads or when the FIFO runs dry, then wait for idle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_almost_empty || (flush && !fifo_empty)) begin
                    state_d = ST_BURST;
                    cnt_d   = 5'd0;
                end
            end
            ST_BURST: begin
                if (fifo_rd_en) begin
                    cnt_d = cnt_q + 5'd1;
                    if (cnt_q + 5'd1 == BL) state_d = ST_DRAIN;
                end else if (fifo_empty) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (!busy_int) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM state and beat counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= 5'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end
`else
    // Stream mode: only emptiness and credit limit reads.
    assign rd_gate = 1'b1;

    logic unused_cfg;
    assign unused_cfg = ^{flush, fifo_almost_empty, BL, ST_IDLE, ST_BURST, ST_DRAIN};
`endif

    fifo_rd_skid #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_skid (
        .clk    (clk),
        .rst    (rst),
        .push_i (pending_q),
        .din_i  (fifo_dout),
        .pop_i  (pop),
        .occ_o  (occ),
        .dout_o (out_data)
    );

endmodule

// File: doc/fifo_rd_ctrl.md
FIFO_RD_CTRL -- requirements
Module: fifo_rd_ctrl

Interface
REQ-001 Parameter DATA_WIDTH, default 8: width of FIFO read data and output stream data.
REQ-002 Parameter BURST_LEN, default 4: beats per burst in burst mode; legal range 2..16.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 fifo_empty  input  1  FIFO empty flag.
REQ-006 fifo_almost_empty  input  1  FIFO almost-empty flag.
REQ-007 fifo_dout  input  DATA_WIDTH  FIFO read data, valid the cycle after an accepted rd_en.
REQ-008 fifo_rd_en  output  1  read request to the FIFO.
REQ-009 flush  input  1  level; forces draining of a partial burst.
REQ-010 out_valid  output  1  stream beat valid.
REQ-011 out_ready  input  1  stream sink ready.
REQ-012 out_data  output  DATA_WIDTH  stream beat data.
REQ-013 busy  output  1  high when any read is in flight or the buffer is non-empty.

Function
REQ-014 Output stage SHALL be a 2-entry in-order buffer; out_valid = occupancy != 0; out_data = head entry.
REQ-015 Beat transfer SHALL occur on a cycle with out_valid && out_ready; head pops at that edge.
REQ-016 fifo_rd_en SHALL never assert while fifo_empty is high.
REQ-017 Credit rule: fifo_rd_en only when occupancy + pending - pop < 2 (pending = rd_en issued previous cycle; pop = transfer this cycle).
REQ-018 Data for a rd_en issued in cycle N SHALL be captured from fifo_dout at the edge ending cycle N+1; out_valid is first high in N+2.
REQ-019 With out_ready held high and FIFO non-empty, sustained throughput SHALL be one beat per cycle.
REQ-020 out_valid held high and out_data stable while out_ready is low; no beat lost or duplicated.
REQ-021 Simultaneous capture and pop SHALL keep occupancy unchanged and preserve order.
REQ-022 busy = pending || occupancy != 0.

Reset
REQ-023 On rst: occupancy 0, pending 0, state IDLE, beat counter 0; fifo_rd_en, out_valid and busy 0 in the same cycle; out_data 0.
REQ-024 rst mid-operation SHALL discard buffered and in-flight data; the in-flight FIFO word is not re-read.

Configuration
REQ-025 Macro FIFO_RD_CTRL_BURST_EN undefined: stream mode; reads issue whenever REQ-016/REQ-017 permit.
REQ-026 Macro FIFO_RD_CTRL_BURST_EN defined: FSM IDLE/BURST/DRAIN gates fifo_rd_en additionally.
REQ-027 IDLE->BURST when !fifo_almost_empty, or when flush && !fifo_empty; beat counter cleared.
REQ-028 BURST: counter increments per issued rd_en; after the BURST_LEN-th issue -> DRAIN; if fifo_empty before BURST_LEN is reached -> DRAIN (short burst).
REQ-029 DRAIN: no reads; -> IDLE when busy is low.

Structure
REQ-030 Shared package fifo_pkg SHALL hold the FSM state encoding (IDLE=2'd0, BURST=2'd1, DRAIN=2'd2) and the buffer depth constant 2.
REQ-031 Sub-module fifo_rd_skid (2-entry output buffer with occupancy) SHALL be instantiated once.

Verification
REQ-032 Stream mode, FIFO preloaded 0x11,0x22,0x33, out_ready=1 -> out_data 0x11,0x22,0x33 on consecutive cycles, first beat 2 cycles after first rd_en.
REQ-033 out_ready=0 for 5 cycles with FIFO holding 6 words -> exactly 2 rd_en, out_data stays 0x11, then 6 beats in order after release.
REQ-034 FIFO empty throughout with toggling out_ready -> fifo_rd_en never high, out_valid 0, busy 0.
REQ-035 Burst mode, BURST_LEN=4, 3 words (almost_empty high), flush=0 -> no reads; flush=1 -> 3 beats, DRAIN, IDLE.
REQ-036 Burst mode, 10 words, almost_empty low -> bursts of 4, 4, then short burst 2 after flush; DRAIN between bursts.
REQ-037 rst asserted with occupancy 2 and pending 1 -> next cycle out_valid 0, busy 0; subsequent beats resume from next FIFO word.
